// File: rtl/sc_imem_loader.sv
// Loads a framed, checksummed byte stream into instruction memory as little-endian
// 32-bit words while holding the CPU core in reset.
//
// state | meaning
// IDLE  | waiting for start; CPU released
// LEN0  | expecting low byte of the word count
// LEN1  | expecting high byte of the word count
// DATA  | collecting the four bytes of the next word
// WRITE | one-cycle write of the assembled word
// CHK   | expecting the XOR checksum byte
// DONE  | load good; CPU released
// ERR   | load failed (bad length or checksum); CPU held in reset
module sc_imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    localparam logic [16:0]       CAPACITY = 17'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

    state_t            state, state_next;
    logic [15:0]       len;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        chk;
    logic [1:0]        byte_idx;
    logic [31:0]       shift;
    logic              consume;
    logic              start_ok;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   wc_next;

    assign consume  = byte_valid & byte_ready;
    assign start_ok = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign len_full = {byte_in, len[7:0]};
    assign wc_next  = word_count + WC_ONE;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = LEN0;
            LEN0:            if (consume) state_next = LEN1;
            LEN1: begin
                if (consume) begin
                    if ({1'b0, len_full} > CAPACITY) begin
                        state_next = ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = CHK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA:            if (consume && byte_idx == 2'd3) state_next = WRITE;
            WRITE:           state_next = (16'(wc_next) == len) ? CHK : DATA;
            CHK:             if (consume) state_next = (byte_in == chk) ? DONE : ERR;
            default:         state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        imem_we    = 1'b0;
        case (state)
            LEN0, LEN1, DATA, CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
        cpu_resetn = resetn & ((state == IDLE) | (state == DONE));
    end

    // Address and data come straight from registers, so they are stable through WRITE.
    assign imem_addr  = word_idx;
    assign imem_wdata = shift;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            len        <= '0;
            word_idx   <= '0;
            word_count <= '0;
            chk        <= '0;
            byte_idx   <= '0;
            shift      <= '0;
        end else if (start_ok) begin
            word_idx   <= '0;
            word_count <= '0;
            chk        <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                LEN0: if (consume) len[7:0] <= byte_in;
                LEN1: if (consume) len[15:8] <= byte_in;
                DATA: begin
                    if (consume) begin
                        shift    <= {byte_in, shift[31:8]};
                        chk      <= chk ^ byte_in;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= wc_next;
                    word_idx   <= word_idx + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sc_imem_loader.md
Name: sc_imem_loader

Overview:
- Writer side of the instruction stream that the single-cycle control path decodes.
- Accepts a framed byte stream on a valid/ready handshake and assembles little-endian 32-bit MIPS instruction words.
- Writes the words sequentially into instruction memory and holds the CPU in reset while loading.
- Sits between the host serial receiver and the sc_computer instruction memory write port.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_W  word address being written.
- imem_wdata  output  32  assembled instruction word.
- cpu_resetn  output  1  active-low reset to the CPU core.
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum.
- error  output  1  last load failed.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes (least-significant byte first per word), then CHK = XOR of all payload bytes.
- A byte is consumed only on a cycle with byte_valid & byte_ready. With byte_ready low, byte_valid is ignored and nothing is consumed.
- States and exits:
  - IDLE: start -> LEN0.
  - LEN0: on consume, latch LEN_LO -> LEN1.
  - LEN1: on consume, latch LEN_HI. If N > 2^ADDR_W -> ERR. If N == 0 -> CHK. Otherwise -> DATA.
  - DATA: consume 4 bytes into a shift register and XOR each into the checksum. The 4th consume -> WRITE.
  - WRITE: lasts exactly one cycle. imem_we=1, imem_addr=word index, imem_wdata=assembled word. At end of cycle word_count++ and word index++. If word_count (new) == N -> CHK, else -> DATA.
  - CHK: on consume, byte == checksum -> DONE, else -> ERR.
  - DONE / ERR: hold until start -> LEN0.
- start clears word index, word_count, checksum, byte index, done and error.
- start while in LEN0..CHK is ignored.
- State-derived outputs:
  - byte_ready=1 only in LEN0, LEN1, DATA, CHK.
  - busy=1 in LEN0, LEN1, DATA, WRITE, CHK.
  - done=1 only in DONE; error=1 only in ERR.
  - cpu_resetn = resetn & (state is IDLE or DONE).
- Latency: 4th byte consumed at edge k -> imem_we high for the cycle after edge k; memory captures at the following edge. byte_ready is low during WRITE, so the minimum is 5 cycles per word.
- Reset (any state, including mid-word): state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, checksum=0, byte index=0, done=0, error=0.
  - A partial word is discarded; words already written stay in memory.
  - cpu_resetn is 0 while resetn is low and 1 from the first cycle in IDLE.
- word_count holds its value through DONE/ERR until the next start.
- imem_addr/imem_wdata are don't-care when imem_we=0 but must not glitch during WRITE.

Test Plan:
- Reset held 2 cycles, then released -> state IDLE, cpu_resetn=1, busy=0, byte_ready=0, imem_we=0; byte_valid=1 with 0xFF is not consumed.
- start, then bytes 02 00 01 00 01 20 00 00 00 08 28 -> writes addr0=0x20010001 and addr1=0x08000000 (one imem_we cycle each); cpu_resetn=0 throughout; then done=1, word_count=2, cpu_resetn=1.
- Same frame with CHK=0x29 -> error=1, done=0, cpu_resetn=0, word_count=2, both words still written.
- start, then bytes 00 00 00 -> no imem_we ever asserted, done=1, word_count=0.
- ADDR_W=8, start, then bytes 01 01 (N=257) -> ERR immediately after LEN_HI, no writes, byte_ready=0.
- Random byte_valid gaps with resetn pulsed low after 5 payload bytes -> word0 written, no second write, state IDLE, word_count=0; a fresh start with the full 2-word frame completes with done=1.
